// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle between a word producer and the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned BYTE = 8
) ();

  logic            tx_valid;
  logic [BYTE-1:0] tx_data;
  logic            tx_ready;
  logic            tx_out;
  logic            tx_busy;

  // Producer side: offers words, observes readiness and line state.
  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  tx_out,
    input  tx_busy
  );

  // Transmitter side: accepts words, drives the serial line.
  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output tx_out,
    output tx_busy
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, framed as start,
// LSB-first data, optional parity and one or two stop bits. Bit timing is a
// counter cleared at frame acceptance so every bit is exactly BAUD_DIV clocks.
module uart_tx #(
  parameter int unsigned CLK_FRQ   = 250000000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned BYTE      = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       areset,
  uart_tx_if.slave   bus
);

  localparam int unsigned BAUD_DIV = CLK_FRQ / BAUD_RATE;
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned IDX_W    = (BYTE > 1) ? $clog2(BYTE) : 1;
  // Unsupported parity codes fall back to no parity; anything but 2 stop bits means 1.
  localparam bit          PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam bit          PAR_ODD  = (PARITY == 1);
  localparam int unsigned STOP_N   = (STOP_BITS == 2) ? 2 : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(BYTE - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q,    state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [IDX_W-1:0]  bit_idx_q,  bit_idx_d;
  logic [BYTE-1:0]   shift_q,    shift_d;
  logic              parity_q,   parity_d;
  logic              tx_out_q,   tx_out_d;
  logic              tx_ready_q, tx_ready_d;
  logic              tx_busy_q,  tx_busy_d;

  logic              bit_end;

  assign bit_end = (baud_cnt_q == BAUD_LAST);

  // State, datapath and registered outputs; reset parks the line high and idle.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // Next-state sequencing and datapath updates; the baud counter only runs mid-frame.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;

    if (state_q != S_IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.tx_valid && tx_ready_q) begin
          shift_d    = bus.tx_data;
          parity_d   = PAR_ODD ? ~(^bus.tx_data) : (^bus.tx_data);
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            state_d   = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = '0;
        bit_idx_d  = '0;
      end
    endcase
  end

  // Output values for the state being entered, so the flops present them in that state.
  always_comb begin
    tx_out_d   = 1'b1;
    tx_ready_d = 1'b0;
    tx_busy_d  = 1'b1;

    case (state_d)
      S_IDLE: begin
        tx_ready_d = 1'b1;
        tx_busy_d  = 1'b0;
      end
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shift_d[0];
      S_PARITY: tx_out_d = parity_d;
      S_STOP:   tx_out_d = 1'b1;
      default:  tx_out_d = 1'b1;
    endcase
  end

  assign bus.tx_out   = tx_out_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parity/stop configurations share one stimulus
// stream, each checked every cycle against a frame-level line model.
module tb_uart_tx;

  localparam int unsigned DIV = 16;
  localparam int          HN  = 2048;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;

  always #5 clk = ~clk;

  uart_tx_if #(.BYTE(8)) if0 ();
  uart_tx_if #(.BYTE(8)) if1 ();
  uart_tx_if #(.BYTE(8)) if2 ();

  assign if0.tx_valid = valid;
  assign if0.tx_data  = data;
  assign if1.tx_valid = valid;
  assign if1.tx_data  = data;
  assign if2.tx_valid = valid;
  assign if2.tx_data  = data;

  uart_tx #(.CLK_FRQ(16), .BAUD_RATE(1), .BYTE(8), .PARITY(0), .STOP_BITS(1))
    u0 (.clk(clk), .areset(areset), .bus(if0));
  uart_tx #(.CLK_FRQ(16), .BAUD_RATE(1), .BYTE(8), .PARITY(2), .STOP_BITS(1))
    u1 (.clk(clk), .areset(areset), .bus(if1));
  uart_tx #(.CLK_FRQ(16), .BAUD_RATE(1), .BYTE(8), .PARITY(1), .STOP_BITS(2))
    u2 (.clk(clk), .areset(areset), .bus(if2));

  logic [2:0] out_w, ready_w, busy_w;
  assign out_w   = {if2.tx_out,   if1.tx_out,   if0.tx_out};
  assign ready_w = {if2.tx_ready, if1.tx_ready, if0.tx_ready};
  assign busy_w  = {if2.tx_busy,  if1.tx_busy,  if0.tx_busy};

  int cfg_par  [3] = '{0, 2, 1};
  int cfg_stop [3] = '{1, 1, 2};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  logic hist_out [3][HN];
  logic hist_rdy [3][HN];

  // Whole frame as a bit vector: start, data LSB first, parity slot, stop ones.
  function automatic logic [11:0] mk_frame(logic [7:0] d, int par);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par == 1) f[9] = ~(^d);
    else if (par == 2) f[9] = ^d;
    return f;
  endfunction

  function automatic int frame_len(int i);
    return DIV * (1 + 8 + ((cfg_par[i] != 0) ? 1 : 0) + cfg_stop[i]);
  endfunction

  // Model: idle until accepted, then walk F cycles through the frame vector.
  bit          m_idle  [3];
  int          m_k     [3];
  logic [11:0] m_frame [3];

  always @(posedge clk or posedge areset) begin
    for (int i = 0; i < 3; i++) begin
      if (areset) begin
        m_idle[i] <= 1'b1;
        m_k[i]    <= 0;
      end else if (m_idle[i]) begin
        if (valid) begin
          m_idle[i]  <= 1'b0;
          m_k[i]     <= 1;
          m_frame[i] <= mk_frame(data, cfg_par[i]);
        end
      end else if (m_k[i] == frame_len(i)) begin
        m_idle[i] <= 1'b1;
      end else begin
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock: compare against the model at negedge, log history, return #1 after posedge.
  task automatic tick();
    logic eo;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      eo = m_idle[i] ? 1'b1 : m_frame[i][(m_k[i] - 1) / DIV];
      check($sformatf("line%0d", i),  32'(out_w[i]),   32'(eo));
      check($sformatf("ready%0d", i), 32'(ready_w[i]), 32'(m_idle[i]));
      check($sformatf("busy%0d", i),  32'(busy_w[i]),  32'(!m_idle[i]));
      hist_out[i][cyc % HN] = out_w[i];
      hist_rdy[i][cyc % HN] = ready_w[i];
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // n counts cycles after the acceptance edge, n=1 being the first start-bit cycle.
  function automatic logic line(int i, int n);
    return hist_out[i][(t0 + n - 1) % HN];
  endfunction

  function automatic int ready_at(int i);
    for (int n = 1; n < 500; n++) begin
      if (hist_rdy[i][(t0 + n - 1) % HN]) return n;
    end
    return -1;
  endfunction

  function automatic logic [7:0] decode(int i, int off);
    logic [7:0] w;
    for (int j = 0; j < 8; j++) w[j] = line(i, off + DIV * (j + 1) + DIV / 2);
    return w;
  endfunction

  task automatic accept(logic [7:0] w);
    valid = 1'b1;
    data  = w;
    tick();
    t0    = cyc;
    valid = 1'b0;
    data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (ready_w != 3'b111 && b < 600) begin
      tick();
      b++;
    end
    tick();
    check("idle_timeout", 32'(ready_w == 3'b111), 32'd1);
  endtask

  initial begin
    int k;
    int first_low;

    // Model pins.
    check("model_a5", 32'(mk_frame(8'hA5, 0)), 32'h0F4A);
    check("model_07e", 32'(mk_frame(8'h07, 2)), 32'h0E0E);
    check("model_07o", 32'(mk_frame(8'h07, 1)), 32'h0C0E);

    // Reset with random inputs.
    for (int r = 0; r < 6; r++) begin
      valid = 1'($urandom);
      data  = 8'($urandom);
      tick();
    end
    check("rst_out",   32'(out_w),   32'h7);
    check("rst_ready", 32'(ready_w), 32'h7);
    check("rst_busy",  32'(busy_w),  32'h0);
    areset = 1'b0;
    valid  = 1'b0;
    tick();

    // Single frame 0xA5 on all configurations.
    accept(8'hA5);
    wait_idle();
    check("a5_start",  32'(line(0, 8)),   32'd0);
    check("a5_word",   32'(decode(0, 0)), 32'hA5);
    check("a5_stop",   32'(line(0, 152)), 32'd1);
    check("a5_rdy0",   32'(ready_at(0)),  32'd161);
    check("a5_rdy1",   32'(ready_at(1)),  32'd177);
    check("a5_rdy2",   32'(ready_at(2)),  32'd193);

    // Parity bits and two stop bits with 0x07.
    accept(8'h07);
    wait_idle();
    check("p_even",    32'(line(1, 152)), 32'd1);
    check("p_odd",     32'(line(2, 152)), 32'd0);
    check("stop2_a",   32'(line(2, 168)), 32'd1);
    check("stop2_b",   32'(line(2, 192)), 32'd1);
    check("p_rdy1",    32'(ready_at(1)),  32'd177);
    check("p_rdy2",    32'(ready_at(2)),  32'd193);

    // Back-to-back 0x00 then 0xFF with valid held high.
    valid = 1'b1;
    data  = 8'h00;
    tick();
    t0   = cyc;
    data = 8'hFF;
    k = 0;
    while (k < 300) begin
      if (ready_w[0]) begin
        tick();
        valid = 1'b0;
        break;
      end
      tick();
      k++;
    end
    valid = 1'b0;
    wait_idle();
    first_low = -1;
    for (int n = 145; n < 400; n++) begin
      if (line(0, n) == 1'b0) begin
        first_low = n;
        break;
      end
    end
    check("b2b_start2", 32'(first_low),       32'd162);
    check("b2b_gap",    32'(first_low - 145), 32'd17);
    check("b2b_word1",  32'(decode(0, 0)),    32'h00);
    check("b2b_word2",  32'(decode(0, 161)),  32'hFF);
    check("b2b_w1_u1",  32'(decode(1, 0)),    32'h00);

    // Inputs wiggle mid-frame; the latched 0x3C must survive.
    accept(8'h3C);
    for (int r = 0; r < 140; r++) begin
      valid = 1'($urandom);
      data  = 8'($urandom);
      tick();
    end
    valid = 1'b0;
    data  = 8'h00;
    wait_idle();
    check("stab_word0", 32'(decode(0, 0)), 32'h3C);
    check("stab_word2", 32'(decode(2, 0)), 32'h3C);
    check("stab_rdy0",  32'(ready_at(0)),  32'd161);
    check("stab_rdy2",  32'(ready_at(2)),  32'd193);

    // Reset during data bit 4 of 0x55, then a clean 0x81.
    accept(8'h55);
    repeat (87) tick();
    #2;
    areset = 1'b1;
    #1;
    check("mid_rst_out",   32'(out_w),   32'h7);
    check("mid_rst_ready", 32'(ready_w), 32'h7);
    check("mid_rst_busy",  32'(busy_w),  32'h0);
    repeat (3) tick();
    areset = 1'b0;
    tick();
    check("post_rst_ready", 32'(ready_w), 32'h7);
    accept(8'h81);
    wait_idle();
    check("post_word0", 32'(decode(0, 0)), 32'h81);
    check("post_word1", 32'(decode(1, 0)), 32'h81);
    check("post_rdy0",  32'(ready_at(0)),  32'd161);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that drives the line consumed by the UART receive path. It accepts one parallel word per valid/ready handshake and serialises it onto `tx_out`: start bit, BYTE data bits LSB first, optional parity bit, then one or two stop bits. Bit timing comes from an internal baud divider derived from the same CLK_FRQ/BAUD_RATE parameters as the receive path.

## Interface
Parameters:
- CLK_FRQ, 250000000: clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bits/s. BAUD_DIV = CLK_FRQ / BAUD_RATE (integer floor). BAUD_DIV must be ≥ 2.
- BYTE, 8: data bits per frame.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- areset, in, 1: asynchronous, active-high reset.
- tx_valid, in, 1: upstream has a word on tx_data.
- tx_data, in, BYTE: word to send.
- tx_ready, out, 1: block can accept a word this cycle.
- tx_out, out, 1: serial line; idles high.
- tx_busy, out, 1: a frame is in progress.

## Operation
- Reset values: tx_out=1, tx_ready=1, tx_busy=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- All outputs are registered; none is combinational from inputs.
- State machine: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE.
- IDLE: tx_out=1, tx_ready=1, tx_busy=0. On tx_valid && tx_ready:
  - latch tx_data into the shift register;
  - compute the parity bit: even = ^tx_data, odd = ~^tx_data;
  - clear the baud counter and go to START.
- START: tx_out=0 for BAUD_DIV cycles.
- DATA: tx_out=shift[0]; shift right each bit period; bit index counts 0..BYTE-1. Leave after bit BYTE-1 completes.
- PARITY: tx_out=latched parity bit for one bit period.
- STOP: tx_out=1 for STOP_BITS × BAUD_DIV cycles, then go to IDLE.
- Baud counter: counts 0..BAUD_DIV-1 and is cleared at frame acceptance, so every bit lasts exactly BAUD_DIV clocks. It is free of drift relative to frame start and does not run in IDLE.
- tx_data and tx_valid are ignored outside IDLE. The latched word is immune to input changes mid-frame.
- An invalid PARITY value (3) behaves as 0. An invalid STOP_BITS value (anything other than 2) behaves as 1.

## Timing
- Handshake cycle T (tx_valid && tx_ready high at edge T):
  - at T+1: tx_out=0, tx_ready=0, tx_busy=1.
  - tx_out change is therefore 1 clock after acceptance.
- Frame length: F = BAUD_DIV × (1 + BYTE + (PARITY≠0) + STOP_BITS) clocks, from T+1 through T+F.
- At T+F+1: state=IDLE, tx_ready=1, tx_busy=0, tx_out=1.
- Back-to-back: if tx_valid is held high, the next acceptance happens at edge T+F+1. The start bit appears at T+F+2, which gives a minimum line-high gap of exactly 1 clock beyond the stop bit(s).
- tx_valid asserted while tx_ready=0: no acceptance. The request must be held until tx_ready=1. It is not queued.
- areset mid-frame: tx_out goes high immediately (asynchronous) and the frame is abandoned. After release, the block is in IDLE with tx_ready=1 on the first clock.
- areset released while tx_valid is high: acceptance may occur on the first rising edge after release.

## Test plan
Common parameters: CLK_FRQ=16, BAUD_RATE=1 (BAUD_DIV=16), BYTE=8 unless stated.
- Reset: hold areset with random inputs → tx_out=1, tx_ready=1, tx_busy=0.
- Single frame, PARITY=0, STOP_BITS=1: send 0xA5.
  - Line reads 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1.
  - Each level lasts 16 clocks; F=160.
  - tx_ready returns high at T+161.
- Parity:
  - PARITY=2 (even), send 0x07 → parity bit 1, F=176.
  - PARITY=1 (odd), send 0x07 → parity bit 0.
  - STOP_BITS=2 → stop high for 32 clocks.
- Back-to-back: tx_valid held high with 0x00 then 0xFF.
  - Second start bit falls at exactly T+162.
  - Line high between frames for 17 clocks.
  - Neither word is dropped or duplicated.
- Input stability: change tx_data and toggle tx_valid during a frame carrying 0x3C.
  - The serialised word remains 0x3C.
  - No extra acceptance occurs until tx_ready=1.
- Reset mid-frame: assert areset during data bit 4 of 0x55.
  - tx_out=1 immediately.
  - After release: tx_ready=1, and a new frame 0x81 is transmitted correctly.
